// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: register-file sizing and the
// buffered LSU result entry.
package writeback_unit_pkg;

    localparam int REGISTER_FILE_SIZE = 32;
    localparam int REG_ID_WIDTH       = 5;
    localparam int WB_DATA_WIDTH      = 32;

    typedef struct packed {
        logic [REG_ID_WIDTH-1:0]  rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Synchronous FIFO of LSU results awaiting a free register-file write slot.
// Push while full is ignored unless a pop frees the slot in the same cycle.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and LSU results onto the single register-file write port
// (ALU first, then buffered LSU, then LSU bypass) and tracks outstanding loads.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int REG_COUNT  = REGISTER_FILE_SIZE,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    output logic                  rf_write_en,
    output logic [4:0]            rf_write_id,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [REG_COUNT-1:0]  pending,
    output logic                  wb_stall
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic                  alu_write;
    logic                  lsu_live;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  bypass;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    wb_entry_t             fifo_head;
    wb_entry_t             lsu_entry;
    logic                  clr_en;
    logic [4:0]            clr_rd;
    logic                  wr_en_q, wr_en_d;
    logic [4:0]            wr_id_q, wr_id_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [REG_COUNT-1:0]  pending_q, pending_d;

    // x0 results count as absent: an x0 ALU write frees the port, an x0 load is accepted and dropped.
    assign alu_write = alu_valid && (alu_rd != '0);
    assign lsu_ready = !fifo_full && !reset;
    assign lsu_live  = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign fifo_push = lsu_live && !bypass;
    assign wb_stall  = (fifo_count == CW'(BUF_DEPTH));
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (lsu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_id_d   = '0;
        wr_data_d = '0;
        fifo_pop  = 1'b0;
        bypass    = 1'b0;
        clr_en    = 1'b0;
        clr_rd    = '0;
        if (alu_write) begin
            wr_en_d   = 1'b1;
            wr_id_d   = alu_rd;
            wr_data_d = alu_data;
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            wr_en_d   = 1'b1;
            wr_id_d   = fifo_head.rd;
            wr_data_d = fifo_head.data;
            clr_en    = 1'b1;
            clr_rd    = fifo_head.rd;
        end else if (lsu_live) begin
            bypass    = 1'b1;
            wr_en_d   = 1'b1;
            wr_id_d   = lsu_rd;
            wr_data_d = lsu_data;
            clr_en    = 1'b1;
            clr_rd    = lsu_rd;
        end
    end

    // Clear is registered alongside the write, so pending falls exactly when rf_write_en rises.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_id_q   <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_id_q   <= wr_id_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign rf_write_en   = wr_en_q;
    assign rf_write_id   = wr_id_q;
    assign rf_write_data = wr_data_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a queue-based model checked every cycle
// plus literal expectations for each scenario.
module tb_writeback_unit;
    localparam int DW    = 32;
    localparam int RC    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [4:0]    lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          issue_valid = 1'b0;
    logic [4:0]    issue_rd = '0;
    logic          rf_write_en;
    logic [4:0]    rf_write_id;
    logic [DW-1:0] rf_write_data;
    logic [RC-1:0] pending;
    logic          wb_stall;

    int checks = 0;
    int failures = 0;

    writeback_unit #(
        .DATA_WIDTH (DW),
        .REG_COUNT  (RC),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rf_write_en   (rf_write_en),
        .rf_write_id   (rf_write_id),
        .rf_write_data (rf_write_data),
        .pending       (pending),
        .wb_stall      (wb_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered queue of waiting loads and a pending bit per register.
    logic [36:0]   exp_q[$];
    logic          m_en = 1'b0;
    logic [4:0]    m_id = '0;
    logic [DW-1:0] m_data = '0;
    logic [RC-1:0] m_pend = '0;
    logic          m_lsu_in;
    logic          m_lsu_written;
    logic [36:0]   m_head;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_en   = 1'b0;
            m_pend = '0;
        end else begin
            m_lsu_in      = lsu_valid && (exp_q.size() < DEPTH) && (lsu_rd != 5'd0);
            m_lsu_written = 1'b0;
            m_en          = 1'b1;
            if (alu_valid && alu_rd != 5'd0) begin
                m_id   = alu_rd;
                m_data = alu_data;
            end else if (exp_q.size() > 0) begin
                m_head = exp_q.pop_front();
                m_id   = m_head[36:32];
                m_data = m_head[31:0];
                m_pend[m_id] = 1'b0;
            end else if (m_lsu_in) begin
                m_id   = lsu_rd;
                m_data = lsu_data;
                m_pend[m_id] = 1'b0;
                m_lsu_written = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            if (m_lsu_in && !m_lsu_written) exp_q.push_back({lsu_rd, lsu_data});
            if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("lsu_ready", lsu_ready, !reset && (exp_q.size() < DEPTH));
        check("wb_stall", wb_stall, exp_q.size() == DEPTH);
        check("rf_write_en", rf_write_en, m_en);
        if (m_en) begin
            check("rf_write_id", rf_write_id, m_id);
            check("rf_write_data", rf_write_data, m_data);
        end
        check("pending", pending, m_pend);
        if (alu_valid) check("alu_while_stall", wb_stall, 1'b0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    logic [4:0] seen_q[$];
    int         lsu_idx;
    logic       saw_stall;
    logic       saw_not_ready;
    logic       acc;

    initial begin
        // Reset state
        step();
        check("rst_en", rf_write_en, 1'b0);
        check("rst_pending", pending, '0);
        check("rst_ready_low", lsu_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_ready_high", lsu_ready, 1'b1);
        step();

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle();
        check("alu_en", rf_write_en, 1'b1);
        check("alu_id", rf_write_id, 5'd5);
        check("alu_data", rf_write_data, 32'hDEADBEEF);
        step();
        check("alu_done_en", rf_write_en, 1'b0);

        // x0 drop
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        #1;
        check("x0_ready", lsu_ready, 1'b1);
        step();
        idle();
        check("x0_en", rf_write_en, 1'b0);
        check("x0_ready_after", lsu_ready, 1'b1);
        step();
        check("x0_en_later", rf_write_en, 1'b0);

        // ALU/LSU conflict
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        check("conf_pend_rise", pending[7], 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA5A5A5A5;
        step();
        idle();
        check("conf_t1_id", rf_write_id, 5'd3);
        check("conf_t1_pend", pending[7], 1'b1);
        step();
        check("conf_t2_en", rf_write_en, 1'b1);
        check("conf_t2_id", rf_write_id, 5'd7);
        check("conf_t2_data", rf_write_data, 32'hA5A5A5A5);
        check("conf_t2_pend", pending[7], 1'b0);
        step();

        // Backpressure with continuous ALU traffic
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(8 + i);
            step();
        end
        idle();
        lsu_idx = 0;
        saw_stall = 1'b0;
        saw_not_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            alu_valid = (c < 8) && !wb_stall;
            alu_rd    = 5'(1 + c % 3);
            alu_data  = 32'h100 + 32'(c);
            lsu_valid = (lsu_idx < 3);
            lsu_rd    = 5'(8 + lsu_idx);
            lsu_data  = 32'hC000 + 32'(lsu_idx);
            #1;
            if (wb_stall) saw_stall = 1'b1;
            if (lsu_valid && !lsu_ready) saw_not_ready = 1'b1;
            acc = lsu_valid && lsu_ready;
            step();
            if (acc) lsu_idx++;
            if (rf_write_en && rf_write_id >= 5'd8) seen_q.push_back(rf_write_id);
        end
        idle();
        check("bp_stall_seen", saw_stall, 1'b1);
        check("bp_notready_seen", saw_not_ready, 1'b1);
        check("bp_count", seen_q.size(), 3);
        for (int i = 0; i < 3 && i < seen_q.size(); i++) begin
            check("bp_order", seen_q[i], 5'(8 + i));
        end
        check("bp_pend_clear", pending[10:8], 3'b000);
        step();

        // Scoreboard race: set beats clear on the same register
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        check("race_pend_set", pending[4], 1'b1);
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        check("race_wr_id", rf_write_id, 5'd4);
        check("race_pend_kept", pending[4], 1'b1);
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h45;
        step();
        idle();
        check("race_pend_fall", pending[4], 1'b0);
        step();

        // Reset mid-stream with two buffered loads
        issue_valid = 1'b1; issue_rd = 5'd12;
        step();
        issue_rd = 5'd13;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h1200;
        step();
        alu_rd = 5'd2; alu_data = 32'h22;
        lsu_rd = 5'd13; lsu_data = 32'h1300;
        step();
        idle();
        check("mid_full", wb_stall, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_en", rf_write_en, 1'b0);
        check("mid_rst_id", rf_write_id, 5'd0);
        check("mid_rst_data", rf_write_data, 32'd0);
        check("mid_rst_pending", pending, '0);
        check("mid_rst_ready", lsu_ready, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("mid_rel_ready", lsu_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_lost_en", rf_write_en, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Drives the register file write port from two result sources: the single-cycle ALU path and the long-latency load/store unit (LSU). LSU results are buffered in a small FIFO and merged into the single write port with ALU priority. A per-register pending scoreboard is kept for outstanding loads so the hazard logic can stall dependent instructions. The block sits between the execute/memory stages and the register file; its outputs connect directly to the register file's `write_en` / `write_id` / `write_data` inputs.

## Interface
Parameters:
- DATA_WIDTH, 32, result and write-data width
- REG_COUNT, REGISTER_FILE_SIZE (32), number of architectural registers; register id width is 5 bits
- BUF_DEPTH, 2, LSU result FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  LSU result accepted when lsu_valid && lsu_ready
- lsu_rd  in  5  load destination register
- lsu_data  in  DATA_WIDTH  load result
- issue_valid  in  1  a load is issued this cycle
- issue_rd  in  5  destination of the issued load
- rf_write_en  out  1  registered register file write enable
- rf_write_id  out  5  registered write register id
- rf_write_data  out  DATA_WIDTH  registered write data
- pending  out  REG_COUNT  bit i set = load to register i outstanding
- wb_stall  out  1  FIFO full; the core must hold the ALU result (alu_valid=0) this cycle

## Operation
- Each cycle the block selects at most one write, in this priority order: ALU result, then FIFO head, then the incoming LSU result (bypass, taken only when the FIFO is empty).
- An LSU result that is accepted but not selected is pushed into the FIFO. If the FIFO head is selected in the same cycle, push and pop both happen.
- lsu_ready = !full. It is 0 while reset is high.
- wb_stall = (count == BUF_DEPTH). Asserting alu_valid while wb_stall=1 is a protocol violation and the bench flags it.
- Writes to register 0:
  - No write with rd==0 ever asserts rf_write_en.
  - An ALU result with rd==0 counts as "no ALU write", so the FIFO can drain that cycle.
  - An LSU result with rd==0 is accepted and dropped. It is neither pushed nor written.
- Scoreboard:
  - issue_valid with issue_rd≠0 sets pending[issue_rd].
  - Selecting an LSU entry (FIFO or bypass) clears pending[rd].
  - If a set and a clear hit the same rd in the same cycle, the set wins.
  - pending[0] is always 0.
  - ALU writes never change the pending bits.
- Reset, whether idle or mid-operation: the FIFO is emptied (buffered results are lost), pending is cleared, and rf_write_en, rf_write_id and rf_write_data are all 0. Write data in flight is discarded.

## Timing
- ALU path: alu_valid at edge t produces rf_write_en at t+1. The path is fully pipelined, 1 write per cycle.
- LSU bypass (FIFO empty, no ALU write): accepted at t, written at t+1.
- LSU through the FIFO: written at the first cycle after push in which there is no ALU write, plus 1 cycle of output latency.
- pending:
  - It is registered: the bit rises the cycle after issue_valid.
  - It falls in the same cycle that rf_write_en for that load asserts, so the hazard logic never sees pending=0 before the data reaches the register file.
- FIFO order is strict. LSU results are written in acceptance order.
- With alu_valid held continuously, the FIFO fills, wb_stall rises, and the forced ALU bubble lets exactly one entry drain per stalled cycle.

## Structure
- In common:
  - `wb_entry_t` packed struct {logic [4:0] rd; logic [DATA_WIDTH-1:0] data;}
  - REGISTER_FILE_SIZE is reused from common, not redefined.
- Sub-module `wb_fifo`:
  - synchronous FIFO of wb_entry_t, depth BUF_DEPTH
  - ports: push, pop, head, full, empty, count
  - asynchronous active-high reset
- The top level contains the select mux, the output registers and the scoreboard.

## Test plan
- Reset: reset=1 mid-stream with 2 entries buffered → next cycle rf_write_en=0, pending=0, lsu_ready=1 after release.
- ALU only: alu_valid, rd=5, data=0xDEADBEEF at t → t+1 rf_write_en=1, id=5, data=0xDEADBEEF.
- x0 drop: alu rd=0 and lsu rd=0, data 0x1234 → rf_write_en never 1; lsu_ready stays 1.
- Conflict: issue rd=7, then alu rd=3 and lsu rd=7 data 0xA5A5A5A5 in the same cycle → t+1 writes x3, t+2 writes x7=0xA5A5A5A5; pending[7] falls at t+2.
- Backpressure: continuous alu_valid plus 3 LSU results (rd 8, 9, 10) → FIFO full, lsu_ready=0, wb_stall=1; on ALU bubbles x8, x9, x10 are written in order.
- Scoreboard race: pending[4]=1, LSU rd=4 write and issue_valid rd=4 in the same cycle → pending[4] stays 1.
